rx_unstuff_shift: RTL

RX_UNSTUFF_SHIFT -- requirements
Module: rx_unstuff_shift

---
 rtl/rx_unstuff_shift.sv | 95 +++++++++
 1 files changed

// File: rtl/rx_unstuff_shift.sv
// rx_unstuff_shift
//   Receive-side bit unstuffer and word assembler. Each shift_enable strobe
//   presents one NRZI-decoded bit. After STUFF_LEN consecutive 1s, the next
//   bit is a stuff bit and is discarded. It must be 0, and a 1 in that
//   position sets stuff_err. Data bits are assembled LSB-first into
//   DATA_W-bit words.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   d_orig       in   decoded data bit, valid when shift_enable is high
//   shift_enable in   one-cycle bit sample strobe
//   eop          in   end-of-packet flag, qualified by shift_enable
//   clear        in   synchronous start-of-packet realign
//   rx_data      out  last completed word (bit 0 = first received)
//   byte_ready   out  one-cycle pulse when rx_data is updated
//   stuff_err    out  sticky: a 1 arrived in a stuff-bit position
//   align_err    out  sticky: eop arrived with a partial word pending
module rx_unstuff_shift #(
    parameter int unsigned STUFF_LEN = 6,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_orig,
    input  logic              shift_enable,
    input  logic              eop,
    input  logic              clear,
    output logic [DATA_W-1:0] rx_data,
    output logic              byte_ready,
    output logic              stuff_err,
    output logic              align_err
);

    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned ONES_W = (STUFF_LEN > 0) ? $clog2(STUFF_LEN + 1) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);

    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ONES_W-1:0] ones_cnt;

    // New bits enter at the MSB, so the first bit received ends up at bit 0.
    assign shift_next = {d_orig, shift_reg[DATA_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            rx_data    <= '0;
            byte_ready <= 1'b0;
            stuff_err  <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            byte_ready <= 1'b0;
            if (clear) begin
                // A strobe in the same cycle as clear is dropped.
                bit_cnt   <= '0;
                ones_cnt  <= '0;
                stuff_err <= 1'b0;
                align_err <= 1'b0;
            end else if (shift_enable && eop) begin
                if (bit_cnt != '0) begin
                    align_err <= 1'b1;
                end
                bit_cnt  <= '0;
                ones_cnt <= '0;
            end else if (shift_enable) begin
                if (ones_cnt == ONES_MAX) begin
                    // Stuff-bit slot: discard the bit and keep the word position.
                    ones_cnt <= '0;
                    if (d_orig) begin
                        stuff_err <= 1'b1;
                    end
                end else begin
                    shift_reg <= shift_next;
                    // The run of 1s is not reset at word boundaries.
                    ones_cnt  <= d_orig ? ones_cnt + ONES_W'(1) : '0;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt    <= '0;
                        rx_data    <= shift_next;
                        byte_ready <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
